// File: rtl/remote_pkg.sv
// Shared types and constants for the remote channel scheduler.
package remote_pkg;

  typedef enum logic [1:0] {ST_OFF, ST_INIT, ST_RUN, ST_DISARM} state_t;

  localparam logic [1:0] CH_THROTTLE = 2'd0;
  localparam logic [1:0] CH_YAW      = 2'd1;
  localparam logic [1:0] CH_PITCH    = 2'd2;
  localparam logic [1:0] CH_ROLL     = 2'd3;

  localparam logic [7:0] NEUTRAL_DEFAULT      = 8'd128;
  localparam logic [7:0] THROTTLE_MIN_DEFAULT = 8'd0;

  typedef struct packed {
    logic [7:0] throttle;
    logic [7:0] yaw;
    logic [7:0] pitch;
    logic [7:0] roll;
  } stick_set_t;

  function automatic logic [7:0] chan_value(input stick_set_t s, input logic [1:0] ch);
    case (ch)
      CH_THROTTLE: chan_value = s.throttle;
      CH_YAW:      chan_value = s.yaw;
      CH_PITCH:    chan_value = s.pitch;
      default:     chan_value = s.roll;
    endcase
  endfunction

endpackage

// File: rtl/init_timer.sv
// Saturating cycle counter with synchronous clear; done once LIMIT cycles have elapsed.
module init_timer #(
  parameter int unsigned LIMIT = 400
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      count <= '0;
    end else if (enable && count != LIMIT_W) begin
      count <= count + W'(1);
    end
  end

  assign done = (count == LIMIT_W);

endmodule

// File: rtl/remote_channel_scheduler.sv
// Sequences arming, stick rounds and a safe disarm round onto a 4-channel DAC
// through a ready/write handshake.
//
//   state     | meaning
//   ST_OFF    | idle, no DAC writes
//   ST_INIT   | arming rounds: init_signal on ch0, neutral elsewhere
//   ST_RUN    | gesture rounds from a per-round snapshot, armed high
//   ST_DISARM | one round of safe values, then back to OFF
module remote_channel_scheduler
  import remote_pkg::*;
#(
  parameter int unsigned INIT_CYCLES  = 400,
  parameter logic [7:0]  NEUTRAL      = NEUTRAL_DEFAULT,
  parameter logic [7:0]  THROTTLE_MIN = THROTTLE_MIN_DEFAULT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       on_state,
  input  logic [7:0] init_signal,
  input  logic       gesture_valid,
  input  logic [7:0] gesture_throttle,
  input  logic [7:0] gesture_yaw,
  input  logic [7:0] gesture_pitch,
  input  logic [7:0] gesture_roll,
  input  logic       dac_ready,
  output logic       dac_write,
  output logic [7:0] dac_data,
  output logic [1:0] dac_chan,
  output logic       armed
);

  localparam stick_set_t SAFE_SET = '{throttle: THROTTLE_MIN, yaw: NEUTRAL,
                                      pitch: NEUTRAL, roll: NEUTRAL};

  state_t     state, state_next;
  stick_set_t holding, round_set;
  logic [1:0] chan_next;
  logic [7:0] data_next;
  logic       write_next;
  logic       snap;
  logic       init_done;
  logic       xfer_done;

  assign xfer_done = dac_write & dac_ready;

  init_timer #(.LIMIT(INIT_CYCLES)) u_init_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state != ST_INIT),
    .enable  (state == ST_INIT),
    .done    (init_done)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_OFF;
      dac_write <= 1'b0;
      dac_data  <= 8'd0;
      dac_chan  <= CH_THROTTLE;
      armed     <= 1'b0;
      holding   <= SAFE_SET;
      round_set <= SAFE_SET;
    end else begin
      state     <= state_next;
      dac_write <= write_next;
      dac_data  <= data_next;
      dac_chan  <= chan_next;
      armed     <= (state_next == ST_RUN);
      if (gesture_valid) begin
        holding <= '{throttle: gesture_throttle, yaw: gesture_yaw,
                     pitch: gesture_pitch, roll: gesture_roll};
      end
      if (snap) begin
        round_set <= holding;
      end
    end
  end

  // A new word is only loaded on a completed transfer, so a stalled word holds.
  always_comb begin
    state_next = state;
    chan_next  = dac_chan;
    write_next = dac_write;
    data_next  = dac_data;
    snap       = 1'b0;
    case (state)
      ST_OFF: begin
        write_next = 1'b0;
        if (on_state) begin
          state_next = ST_INIT;
          write_next = 1'b1;
          chan_next  = CH_THROTTLE;
          data_next  = init_signal;
        end
      end
      ST_INIT, ST_RUN: begin
        if (xfer_done) begin
          chan_next = dac_chan + 2'd1;
          if (!on_state) begin
            state_next = ST_DISARM;
            chan_next  = CH_THROTTLE;
            data_next  = THROTTLE_MIN;
          end else if (state == ST_RUN || (dac_chan == CH_ROLL && init_done)) begin
            state_next = ST_RUN;
            snap       = (chan_next == CH_THROTTLE);
            data_next  = chan_value(snap ? holding : round_set, chan_next);
          end else begin
            data_next = (chan_next == CH_THROTTLE) ? init_signal : NEUTRAL;
          end
        end
      end
      ST_DISARM: begin
        if (xfer_done) begin
          chan_next = dac_chan + 2'd1;
          data_next = NEUTRAL;
          if (dac_chan == CH_ROLL) begin
            state_next = ST_OFF;
            write_next = 1'b0;
            data_next  = THROTTLE_MIN;
          end
        end
      end
      default: state_next = ST_OFF;
    endcase
  end

endmodule

// File: tb/tb_remote_channel_scheduler.sv
// Directed scenarios plus randomized traffic, checked against a round-level
// behavioural model of the scheduler.
module tb_remote_channel_scheduler;

  localparam int unsigned INIT_CYCLES  = 8;
  localparam logic [7:0]  NEUTRAL      = 8'h80;
  localparam logic [7:0]  THROTTLE_MIN = 8'h00;
  localparam int M_OFF = 0, M_INIT = 1, M_RUN = 2, M_DISARM = 3;

  logic       clock = 1'b0;
  logic       reset_n, on_state, gesture_valid, dac_ready;
  logic [7:0] init_signal, g_thr, g_yaw, g_pitch, g_roll;
  logic       dac_write, armed;
  logic [7:0] dac_data;
  logic [1:0] dac_chan;

  int n_checks = 0;
  int n_pass   = 0;

  // model: activity, current presented word, per-round stick sets
  int         m_mode, m_cnt;
  logic       m_write, m_armed;
  logic [1:0] m_chan;
  logic [7:0] m_data;
  logic [7:0] m_hold [4];
  logic [7:0] m_round [4];
  logic [9:0] xfer_log [$];

  logic [9:0] exp_pwr [4] = '{10'h010, 10'h180, 10'h280, 10'h380};
  logic [9:0] exp_g [8]   = '{10'h040, 10'h120, 10'h2E0, 10'h390,
                              10'h041, 10'h121, 10'h2E1, 10'h391};
  logic [9:0] exp_dis [5] = '{10'h121, 10'h000, 10'h180, 10'h280, 10'h380};

  remote_channel_scheduler #(
    .INIT_CYCLES(INIT_CYCLES), .NEUTRAL(NEUTRAL), .THROTTLE_MIN(THROTTLE_MIN)
  ) dut (
    .clock(clock), .reset_n(reset_n), .on_state(on_state), .init_signal(init_signal),
    .gesture_valid(gesture_valid), .gesture_throttle(g_thr), .gesture_yaw(g_yaw),
    .gesture_pitch(g_pitch), .gesture_roll(g_roll), .dac_ready(dac_ready),
    .dac_write(dac_write), .dac_data(dac_data), .dac_chan(dac_chan), .armed(armed)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic present(input int ch, input logic [7:0] d);
    m_write = 1'b1;
    m_chan  = 2'(ch);
    m_data  = d;
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_update();
    bit done;
    int nxt, c;
    done = m_write && dac_ready;
    if (!reset_n) begin
      m_mode = M_OFF; m_cnt = 0; m_write = 1'b0; m_chan = 2'd0; m_data = 8'd0;
      m_hold  = '{THROTTLE_MIN, NEUTRAL, NEUTRAL, NEUTRAL};
      m_round = '{THROTTLE_MIN, NEUTRAL, NEUTRAL, NEUTRAL};
      m_armed = 1'b0;
      return;
    end
    nxt = (int'(m_chan) + 1) % 4;
    case (m_mode)
      M_OFF: begin
        m_write = 1'b0;
        if (on_state) begin
          m_mode = M_INIT;
          m_cnt  = 0;
          present(0, init_signal);
        end
      end
      M_INIT, M_RUN: begin
        c = m_cnt;
        m_cnt = c + 1;
        if (done) begin
          if (!on_state) begin
            m_mode = M_DISARM;
            present(0, THROTTLE_MIN);
          end else if (m_mode == M_RUN || (nxt == 0 && c >= int'(INIT_CYCLES))) begin
            m_mode = M_RUN;
            if (nxt == 0) m_round = m_hold;
            present(nxt, m_round[nxt]);
          end else begin
            present(nxt, (nxt == 0) ? init_signal : NEUTRAL);
          end
        end
      end
      default: begin
        if (done) begin
          if (nxt == 0) begin
            m_mode = M_OFF;
            m_write = 1'b0;
          end else begin
            present(nxt, NEUTRAL);
          end
        end
      end
    endcase
    if (gesture_valid) m_hold = '{g_thr, g_yaw, g_pitch, g_roll};
    m_armed = (m_mode == M_RUN);
  endtask

  task automatic cycle();
    model_update();
    if (dac_write && dac_ready) xfer_log.push_back({dac_chan, dac_data});
    @(posedge clock);
    @(negedge clock);
    check_val("write", dac_write, m_write);
    check_val("armed", armed, m_armed);
    if (m_write) begin
      check_val("chan", dac_chan, m_chan);
      check_val("data", dac_data, m_data);
    end
  endtask

  initial begin
    int n, mark;
    reset_n = 1'b0; on_state = 1'b0; gesture_valid = 1'b0; dac_ready = 1'b0;
    init_signal = 8'h10; g_thr = 8'h00; g_yaw = 8'h00; g_pitch = 8'h00; g_roll = 8'h00;
    repeat (3) cycle();
    check_val("rst_data", dac_data, 8'h00);
    check_val("rst_chan", dac_chan, 2'd0);

    // reset while a word is stalled
    reset_n = 1'b1; on_state = 1'b1;
    repeat (3) cycle();
    check_val("stall_before_rst", dac_write, 1'b1);
    reset_n = 1'b0;
    cycle();
    check_val("rst_mid_write", dac_write, 1'b0);
    check_val("rst_mid_armed", armed, 1'b0);

    // power-up through INIT
    reset_n = 1'b1; dac_ready = 1'b1;
    mark = xfer_log.size();
    n = 0;
    while (!armed && n < 40) begin cycle(); n++; end
    check_val("arm_latency", n, 13);
    for (int i = 0; i < 4; i++) check_val("init_round", xfer_log[mark + i], exp_pwr[i]);

    // gesture sets never mix within a round
    mark = xfer_log.size();
    gesture_valid = 1'b1; g_thr = 8'h40; g_yaw = 8'h20; g_pitch = 8'hE0; g_roll = 8'h90;
    cycle();
    gesture_valid = 1'b0;
    repeat (4) cycle();
    gesture_valid = 1'b1; g_thr = 8'h41; g_yaw = 8'h21; g_pitch = 8'hE1; g_roll = 8'h91;
    cycle();
    gesture_valid = 1'b0;
    repeat (6) cycle();
    for (int i = 0; i < 8; i++) check_val("gesture_round", xfer_log[mark + 4 + i], exp_g[i]);

    // stall on ch2
    repeat (2) cycle();
    dac_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_val("stall_chan", dac_chan, 2'd2);
      check_val("stall_data", dac_data, 8'hE1);
    end
    dac_ready = 1'b1;
    cycle();
    check_val("after_stall_chan", dac_chan, 2'd3);

    // on_state drop while ch1 is stalled
    repeat (2) cycle();
    dac_ready = 1'b0; on_state = 1'b0;
    repeat (3) cycle();
    check_val("drop_stall_armed", armed, 1'b1);
    dac_ready = 1'b1;
    mark = xfer_log.size();
    cycle();
    check_val("disarm_entry_armed", armed, 1'b0);
    repeat (4) cycle();
    check_val("disarm_off_write", dac_write, 1'b0);
    for (int i = 0; i < 5; i++) check_val("disarm_round", xfer_log[mark + i], exp_dis[i]);

    // on_state re-asserted during DISARM
    on_state = 1'b1;
    n = 0;
    while (!armed && n < 40) begin cycle(); n++; end
    check_val("rearm_latency", n, 13);
    on_state = 1'b0;
    cycle();
    on_state = 1'b1;
    repeat (4) cycle();
    check_val("reenter_off", dac_write, 1'b0);
    cycle();
    check_val("reenter_init_write", dac_write, 1'b1);
    check_val("reenter_init_chan", dac_chan, 2'd0);

    for (int i = 0; i < 4000; i++) begin
      reset_n = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 59) == 0) on_state = ~on_state;
      dac_ready = ($urandom_range(0, 9) < 7);
      gesture_valid = ($urandom_range(0, 7) == 0);
      g_thr = 8'($urandom); g_yaw = 8'($urandom);
      g_pitch = 8'($urandom); g_roll = 8'($urandom);
      init_signal = 8'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
